ecc_apb_job_master: RTL and testbench
=====================================

# ecc_apb_job_master

APB write-sequencer that sits directly upstream of the ECC encoder/decoder APB slave. It accepts one ECC job per valid/ready handshake and programs the slave registers with back-to-back APB writes: NOISE, CODEWORD_WIDTH, DATA_IN, then CTRL. It then waits for `operation_done`, captures `data_out`/`num_of_errors`, and returns them on a valid/ready result port with a status code.

## Interface
- `AMBA_WORD`, 16, APB data width.
- `AMBA_ADDR_WIDTH`, 20, APB address width.
- `DATA_WIDTH`, 16, job data width; must be ≤ `AMBA_WORD`.
- `TIMEOUT_CYCLES`, 255, maximum WAIT_DONE cycles before abort; must be ≥ 1.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  job offered.
- `job_ready`  out  1  high only in IDLE.
- `job_mode`  in  2  00 encode, 01 decode, 10 full channel, 11 illegal.
- `job_width`  in  2  codeword width code written to CODEWORD_WIDTH.
- `job_data`  in  DATA_WIDTH  word written to DATA_IN.
- `job_noise`  in  DATA_WIDTH  word written to NOISE.
- `PADDR`  out  AMBA_ADDR_WIDTH  APB address.
- `PSEL`  out  1  APB select.
- `PENABLE`  out  1  APB enable.
- `PWRITE`  out  1  APB write strobe.
- `PWDATA`  out  AMBA_WORD  APB write data.
- `operation_done`  in  1  slave completion pulse.
- `data_out`  in  DATA_WIDTH  slave result word.
- `num_of_errors`  in  2  slave error count.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_data`  out  DATA_WIDTH  captured `data_out`.
- `res_errors`  out  2  captured `num_of_errors`.
- `res_status`  out  2  00 ok, 01 timeout, 10 illegal mode.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SETUP, ACCESS, WAIT_DONE, RESULT.
- Register order and index: 0 NOISE (0xC), 1 CODEWORD_WIDTH (0x8), 2 DATA_IN (0x4), 3 CTRL (0x0). Addresses are zero-extended to `AMBA_ADDR_WIDTH`.
- On `job_valid && job_ready`:
  - Latch all job fields.
  - Mode 11: go directly to RESULT with status 10, `res_data` = 0, `res_errors` = 0. No APB traffic.
  - Otherwise: index = 0, go to SETUP.
- SETUP: `PSEL`=1, `PENABLE`=0, `PWRITE`=1, `PADDR`/`PWDATA` for the current index. Next state ACCESS.
- ACCESS: same `PSEL`/`PADDR`/`PWDATA`, `PENABLE`=1. The slave has no wait states.
  - Index < 3: increment index, go to SETUP. Transfers run back-to-back with no idle cycle.
  - Index = 3: clear the timeout counter, go to WAIT_DONE.
- PWDATA zero-extension to `AMBA_WORD`:
  - NOISE ← `job_noise`.
  - CODEWORD_WIDTH ← `job_width`.
  - DATA_IN ← `job_data`.
  - CTRL ← `job_mode`.
- WAIT_DONE: counter increments every cycle.
  - `operation_done`=1: capture `data_out` and `num_of_errors`, status 00, go to RESULT.
  - Else, counter reaches `TIMEOUT_CYCLES`: status 01, `res_data`/`res_errors` = 0, go to RESULT.
  - Both in the same cycle: done wins.
- RESULT: `res_valid`=1 and all result fields held stable. On `res_ready`, go to IDLE.
- `operation_done` outside WAIT_DONE is ignored.
- Job inputs are not sampled outside the handshake cycle.

## Timing
- Reset asserted (any state, including mid-transfer):
  - Immediately: state IDLE; `PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA`, `res_valid`, `res_data`, `res_errors`, `res_status`, `busy` = 0.
  - `job_ready` = 1 (decoded from IDLE).
  - A partially programmed slave is not cleaned up.
- APB outputs are registered. When `PSEL`=0, `PADDR`, `PWDATA` and `PWRITE` are 0.
- Handshake at edge T. Then:
  - NOISE SETUP in cycle T+1, ACCESS in T+2.
  - CODEWORD_WIDTH in T+3/T+4; DATA_IN in T+5/T+6; CTRL in T+7/T+8.
  - WAIT_DONE from T+9.
- `operation_done` sampled high at edge D: `res_valid` = 1 from cycle D+1.
- Timeout: `res_valid` rises exactly `TIMEOUT_CYCLES`+1 cycles after WAIT_DONE entry.
- Illegal mode: `res_valid` = 1 in cycle T+1.
- `res_ready` held high in RESULT: `job_ready` = 1 in the next cycle. Minimum job-to-job spacing is therefore 11 cycles plus slave latency.
- Result handshake and a new job handshake never occur in the same cycle.

## Test plan
- Reset, then a decode job (mode 01, width 0, data 0x00AE, noise 0x0020) → four write pairs (0xC/0x0020, 0x8/0x0000, 0x4/0x00AE, 0x0/0x0001) in cycles T+1..T+8, `PENABLE` alternating 0/1, `PSEL` continuous.
- Slave model pulses `operation_done` 5 cycles after WAIT_DONE entry with `data_out`=0x00AE, errors=1 → `res_valid` next cycle, `res_data`=0x00AE, `res_errors`=01, `res_status`=00. `res_ready` held low for 3 cycles → outputs stable throughout.
- `operation_done` never asserted, `TIMEOUT_CYCLES`=8 → `res_status`=01, `res_data`=0, `res_valid` 9 cycles after WAIT_DONE entry.
- Job with mode 11 → no `PSEL` activity, `res_status`=10, `res_valid` at T+1, `job_ready` low until `res_ready`.
- `rst` asserted during the DATA_IN ACCESS cycle → APB outputs and `busy` drop immediately. After release, `job_ready`=1 and a full-channel job (mode 10) completes normally with CTRL write data 0x0002.
- `operation_done` coincident with the timeout-limit cycle → status 00 with captured data; a stray `operation_done` in IDLE or SETUP → no effect.

Source files
------------

// File: rtl/ecc_apb_job_master.sv
// APB write sequencer for the ECC encoder/decoder slave: programs NOISE,
// CODEWORD_WIDTH, DATA_IN and CTRL per job, then returns the slave result.
module ecc_apb_job_master #(
  parameter int unsigned AMBA_WORD       = 16,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [1:0]                 job_mode,
  input  logic [1:0]                 job_width,
  input  logic [DATA_WIDTH-1:0]      job_data,
  input  logic [DATA_WIDTH-1:0]      job_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic [1:0]                 res_errors,
  output logic [1:0]                 res_status,
  output logic                       busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] MODE_ILLEGAL   = 2'b11;
  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0] STATUS_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_ACCESS    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESULT    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  accept;

  logic [1:0]            mode_q, mode_d;
  logic [1:0]            width_q, width_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] noise_q, noise_d;

  logic [DATA_WIDTH-1:0]      res_data_d;
  logic [1:0]                 res_errors_d;
  logic [1:0]                 res_status_d;
  logic                       psel_d, penable_d, pwrite_d;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_d;
  logic [AMBA_WORD-1:0]       pwdata_d;
  logic                       res_valid_d, busy_d, job_ready_d;

  // State, sequencing index, timeout counter and latched job fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      mode_q  <= 2'd0;
      width_q <= 2'd0;
      data_q  <= '0;
      noise_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      width_q <= width_d;
      data_q  <= data_d;
      noise_q <= noise_d;
    end
  end

  // Next state, sequencing and result capture
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    accept       = 1'b0;
    res_data_d   = res_data;
    res_errors_d = res_errors;
    res_status_d = res_status;
    unique case (state_q)
      S_IDLE: begin
        if (job_valid && job_ready) begin
          accept = 1'b1;
          if (job_mode == MODE_ILLEGAL) begin
            state_d      = S_RESULT;
            res_data_d   = '0;
            res_errors_d = 2'd0;
            res_status_d = STATUS_ILLEGAL;
          end else begin
            idx_d   = 2'd0;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (idx_q == 2'd3) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_SETUP;
        end
      end
      S_WAIT_DONE: begin
        // Completion takes priority over a coincident timeout
        if (operation_done) begin
          res_data_d   = data_out;
          res_errors_d = num_of_errors;
          res_status_d = STATUS_OK;
          state_d      = S_RESULT;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          res_data_d   = '0;
          res_errors_d = 2'd0;
          res_status_d = STATUS_TIMEOUT;
          state_d      = S_RESULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mode_d  = accept ? job_mode  : mode_q;
  assign width_d = accept ? job_width : width_q;
  assign data_d  = accept ? job_data  : data_q;
  assign noise_d = accept ? job_noise : noise_q;

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d   = (state_d == S_ACCESS);
    pwrite_d    = psel_d;
    paddr_d     = '0;
    pwdata_d    = '0;
    res_valid_d = (state_d == S_RESULT);
    busy_d      = (state_d != S_IDLE);
    job_ready_d = (state_d == S_IDLE);
    if (psel_d) begin
      unique case (idx_d)
        2'd0: begin
          paddr_d  = AMBA_ADDR_WIDTH'(4'hC);
          pwdata_d = AMBA_WORD'(noise_d);
        end
        2'd1: begin
          paddr_d  = AMBA_ADDR_WIDTH'(4'h8);
          pwdata_d = AMBA_WORD'(width_d);
        end
        2'd2: begin
          paddr_d  = AMBA_ADDR_WIDTH'(4'h4);
          pwdata_d = AMBA_WORD'(data_d);
        end
        default: begin
          paddr_d  = AMBA_ADDR_WIDTH'(4'h0);
          pwdata_d = AMBA_WORD'(mode_d);
        end
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_errors <= 2'd0;
      res_status <= 2'd0;
      busy       <= 1'b0;
      job_ready  <= 1'b1;
    end else begin
      PSEL       <= psel_d;
      PENABLE    <= penable_d;
      PWRITE     <= pwrite_d;
      PADDR      <= paddr_d;
      PWDATA     <= pwdata_d;
      res_valid  <= res_valid_d;
      res_data   <= res_data_d;
      res_errors <= res_errors_d;
      res_status <= res_status_d;
      busy       <= busy_d;
      job_ready  <= job_ready_d;
    end
  end

endmodule

// File: tb/tb_ecc_apb_job_master.sv
// Scoreboard bench for ecc_apb_job_master: directed jobs, expected APB writes
// and results queued by the stimulus, compared by an independent monitor.
module tb_ecc_apb_job_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [1:0]  job_mode;
  logic [1:0]  job_width;
  logic [15:0] job_data;
  logic [15:0] job_noise;
  logic [19:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PWDATA;
  logic        operation_done;
  logic [15:0] data_out;
  logic [1:0]  num_of_errors;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_errors;
  logic [1:0]  res_status;
  logic        busy;

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } apb_exp_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  err;
    logic [1:0]  st;
  } res_exp_t;

  apb_exp_t apb_q[$];
  res_exp_t res_q[$];
  apb_exp_t mon_apb;
  res_exp_t mon_res;

  int n_checks = 0;
  int n_pass   = 0;

  ecc_apb_job_master #(
    .AMBA_WORD(16),
    .AMBA_ADDR_WIDTH(20),
    .DATA_WIDTH(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_mode(job_mode),
    .job_width(job_width),
    .job_data(job_data),
    .job_noise(job_noise),
    .PADDR(PADDR),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PWDATA(PWDATA),
    .operation_done(operation_done),
    .data_out(data_out),
    .num_of_errors(num_of_errors),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_errors(res_errors),
    .res_status(res_status),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on every APB access phase and result handshake
  always @(negedge clk) begin
    if (rst) begin
      if (PSEL && PENABLE) begin
        check("apb_write_expected", 32'(apb_q.size() > 0), 32'd1);
        if (apb_q.size() > 0) begin
          mon_apb = apb_q.pop_front();
          check("apb_addr", 32'(PADDR), 32'(mon_apb.addr));
          check("apb_wdata", 32'(PWDATA), 32'(mon_apb.data));
          check("apb_pwrite", 32'(PWRITE), 32'd1);
        end
      end else if (!PSEL) begin
        check("apb_idle_addr", 32'(PADDR), 32'd0);
        check("apb_idle_wdata_write", {15'd0, PWRITE, PWDATA}, 32'd0);
      end
      if (res_valid && res_ready) begin
        check("res_expected", 32'(res_q.size() > 0), 32'd1);
        if (res_q.size() > 0) begin
          mon_res = res_q.pop_front();
          check("res_data", 32'(res_data), 32'(mon_res.data));
          check("res_errors", 32'(res_errors), 32'(mon_res.err));
          check("res_status", 32'(res_status), 32'(mon_res.st));
        end
      end
    end
  end

  task automatic wait_job_ready();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (job_ready) break;
    end
    check("job_ready_wait", 32'(job_ready), 32'd1);
  endtask

  // Handshake one job; for legal modes also walk the 8 APB cycles and return in WAIT_DONE entry cycle
  task automatic run_job(input logic [1:0] mode, input logic [1:0] width,
                         input logic [15:0] data, input logic [15:0] noise,
                         input bit stray_setup_done);
    wait_job_ready();
    if (mode != 2'b11) begin
      apb_q.push_back({20'hC, noise});
      apb_q.push_back({20'h8, 14'd0, width});
      apb_q.push_back({20'h4, data});
      apb_q.push_back({20'h0, 14'd0, mode});
    end else begin
      res_q.push_back({16'd0, 2'd0, 2'b10});
    end
    @(posedge clk); #1;
    job_valid = 1'b1; job_mode = mode; job_width = width; job_data = data; job_noise = noise;
    @(posedge clk); #1;
    job_valid = 1'b0; job_mode = ~mode; job_width = ~width; job_data = ~data; job_noise = ~noise;
    if (mode == 2'b11) begin
      @(negedge clk);
      check("illegal_res_valid_t1", 32'(res_valid), 32'd1);
      check("illegal_no_psel", 32'(PSEL), 32'd0);
      check("illegal_job_ready_low", 32'(job_ready), 32'd0);
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        check("illegal_hold_job_ready", 32'(job_ready), 32'd0);
        check("illegal_hold_psel", 32'(PSEL), 32'd0);
        check("illegal_hold_valid", 32'(res_valid), 32'd1);
      end
      return;
    end
    if (stray_setup_done) operation_done = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) operation_done = 1'b0;
      check($sformatf("psel_t%0d", k), 32'(PSEL), 32'd1);
      check($sformatf("penable_t%0d", k), 32'(PENABLE), 32'(k % 2 == 0));
      check($sformatf("busy_t%0d", k), 32'(busy), 32'd1);
      check($sformatf("res_valid_t%0d", k), 32'(res_valid), 32'd0);
    end
    @(negedge clk);
    check("wait_entry_psel", 32'(PSEL), 32'd0);
    check("wait_entry_busy", 32'(busy), 32'd1);
    check("wait_entry_valid", 32'(res_valid), 32'd0);
  endtask

  // From WAIT_DONE entry: drive the slave, check result timing, hold res_ready low, then consume
  task automatic finish_job(input int done_at, input logic [15:0] dout, input logic [1:0] errs,
                            input int exp_at, input logic [15:0] ed, input logic [1:0] ee,
                            input logic [1:0] es);
    res_q.push_back({ed, ee, es});
    for (int k = 1; k <= exp_at; k++) begin
      @(posedge clk); #1;
      operation_done = (k == done_at);
      data_out       = (k == done_at) ? dout : 16'hFFFF;
      num_of_errors  = (k == done_at) ? errs : 2'b11;
      @(negedge clk);
      check($sformatf("res_valid_w%0d", k), 32'(res_valid), 32'(k == exp_at));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", 32'(res_data), 32'(ed));
      check("hold_errors", 32'(res_errors), 32'(ee));
      check("hold_status", 32'(res_status), 32'(es));
    end
  endtask

  task automatic release_result();
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("post_res_job_ready", 32'(job_ready), 32'd1);
    check("post_res_busy", 32'(busy), 32'd0);
    check("post_res_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0; job_valid = 1'b0; job_mode = 2'd0; job_width = 2'd0;
    job_data = 16'd0; job_noise = 16'd0; operation_done = 1'b0;
    data_out = 16'd0; num_of_errors = 2'd0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_job_ready", 32'(job_ready), 32'd1);
    check("rst_res_fields", {12'd0, res_data, res_errors, res_status}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Decode job, slave completes 5 cycles after WAIT_DONE entry
    run_job(2'b01, 2'b00, 16'h00AE, 16'h0020, 1'b0);
    finish_job(5, 16'h00AE, 2'b01, 6, 16'h00AE, 2'b01, 2'b00);
    release_result();

    // Stray completion pulse while idle
    @(posedge clk); #1;
    operation_done = 1'b1; data_out = 16'h7777;
    @(posedge clk); #1;
    operation_done = 1'b0;
    @(negedge clk);
    check("stray_idle_valid", 32'(res_valid), 32'd0);
    check("stray_idle_busy", 32'(busy), 32'd0);

    // Timeout: no completion, limit 8
    run_job(2'b00, 2'b10, 16'h1234, 16'h0000, 1'b0);
    finish_job(-1, 16'h0000, 2'b00, 9, 16'h0000, 2'b00, 2'b01);
    release_result();

    // Illegal mode
    run_job(2'b11, 2'b01, 16'hAAAA, 16'h5555, 1'b0);
    release_result();

    // Reset during the DATA_IN access cycle
    wait_job_ready();
    apb_q.push_back({20'hC, 16'h0F0F});
    apb_q.push_back({20'h8, 16'h0003});
    @(posedge clk); #1;
    job_valid = 1'b1; job_mode = 2'b01; job_width = 2'b11; job_data = 16'hC3C3; job_noise = 16'h0F0F;
    @(posedge clk); #1;
    job_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_access", {11'd0, PSEL, PENABLE, PADDR}, {11'd0, 1'b1, 1'b1, 20'h4});
    rst = 1'b0;
    #1;
    check("mid_rst_psel_penable", {30'd0, PSEL, PENABLE}, 32'd0);
    check("mid_rst_paddr", 32'(PADDR), 32'd0);
    check("mid_rst_pwdata_write", {15'd0, PWRITE, PWDATA}, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_job_ready", 32'(job_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Full-channel job after reset, stray completion during SETUP
    run_job(2'b10, 2'b01, 16'h5A5A, 16'h0101, 1'b1);
    finish_job(2, 16'h5A5B, 2'b10, 3, 16'h5A5B, 2'b10, 2'b00);
    release_result();

    // Completion coincident with the timeout-limit cycle
    run_job(2'b01, 2'b10, 16'h00F0, 16'h0400, 1'b0);
    finish_job(8, 16'hBEEF, 2'b11, 9, 16'hBEEF, 2'b11, 2'b00);
    release_result();

    repeat (2) @(negedge clk);
    check("apb_q_drained", 32'(apb_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no completion by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
